// File: rtl/jk_bank_pkg.sv
// rtl/jk_bank_pkg.sv - opcodes and FSM state encoding shared by the JK bank controller
package jk_bank_pkg;

    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_CLR    = 3'd1;
    localparam logic [2:0] OP_SET    = 3'd2;
    localparam logic [2:0] OP_LOAD   = 3'd3;
    localparam logic [2:0] OP_TOGGLE = 3'd4;
    localparam logic [2:0] OP_UP     = 3'd5;
    localparam logic [2:0] OP_DOWN   = 3'd6;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } st_t;

endpackage

// File: rtl/jk_cell.sv
// rtl/jk_cell.sv - single JK flip-flop with synchronous active-high reset
module jk_cell (
    input  logic clk,
    input  logic rst,
    input  logic J,
    input  logic K,
    output logic Q,
    output logic Qn
);

    logic r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= 1'b0;
        end else begin
            case ({J, K})
                2'b01:   r_q <= 1'b0;
                2'b10:   r_q <= 1'b1;
                2'b11:   r_q <= ~r_q;
                default: r_q <= r_q;
            endcase
        end
    end

    assign Q  = r_q;
    assign Qn = ~r_q;

endmodule

// File: rtl/jk_bank_ctrl.sv
// rtl/jk_bank_ctrl.sv - command sequencer driving J/K inputs of a WIDTH-cell bank
// Optional DOWN counting is built only when JK_BANK_DOWN_EN is defined.
module jk_bank_ctrl
    import jk_bank_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [WIDTH-1:0]  cmd_data,
    input  logic [STEP_W-1:0] cmd_steps,
    output logic [WIDTH-1:0]  Q,
    output logic [WIDTH-1:0]  Qn,
    output logic              done,
    output logic              wrap
);

    st_t               r_state;
    logic [STEP_W-1:0] r_step_cnt;
    logic              r_done;
    logic              r_wrap;

    logic              w_accept;
    logic              w_cnt_op;
    logic              w_cnt_start;
    logic              w_step_wrap;
    logic [WIDTH-1:0]  w_up_t;
    logic [WIDTH-1:0]  w_step_t;
    logic [WIDTH-1:0]  w_j;
    logic [WIDTH-1:0]  w_k;

    assign cmd_ready   = (r_state == ST_IDLE) && !rst;
    assign w_accept    = cmd_valid && cmd_ready;
    assign w_cnt_start = w_accept && w_cnt_op && (cmd_steps != '0);

    // Classic synchronous counter: a cell toggles when all lower cells are 1 (up) or 0 (down).
    assign w_up_t[0] = 1'b1;
    for (genvar i = 1; i < WIDTH; i++) begin : g_up
        assign w_up_t[i] = &Q[i-1:0];
    end

`ifdef JK_BANK_DOWN_EN
    logic             r_down;
    logic [WIDTH-1:0] w_dn_t;

    assign w_dn_t[0] = 1'b1;
    for (genvar i = 1; i < WIDTH; i++) begin : g_dn
        assign w_dn_t[i] = &Qn[i-1:0];
    end

    assign w_cnt_op    = (cmd_op == OP_UP) || (cmd_op == OP_DOWN);
    assign w_step_t    = r_down ? w_dn_t : w_up_t;
    assign w_step_wrap = r_down ? &Qn : &Q;
`else
    assign w_cnt_op    = (cmd_op == OP_UP);
    assign w_step_t    = w_up_t;
    assign w_step_wrap = &Q;
`endif

    always_comb begin
        w_j = '0;
        w_k = '0;
        if (r_state == ST_COUNT) begin
            w_j = w_step_t;
            w_k = w_step_t;
        end else if (w_accept) begin
            case (cmd_op)
                OP_CLR:    w_k = '1;
                OP_SET:    w_j = '1;
                OP_LOAD: begin
                    w_j = cmd_data;
                    w_k = ~cmd_data;
                end
                OP_TOGGLE: begin
                    w_j = cmd_data;
                    w_k = cmd_data;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_step_cnt <= '0;
            r_done     <= 1'b0;
            r_wrap     <= 1'b0;
`ifdef JK_BANK_DOWN_EN
            r_down     <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            r_wrap <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_cnt_start) begin
                        r_state    <= ST_COUNT;
                        r_step_cnt <= cmd_steps;
`ifdef JK_BANK_DOWN_EN
                        r_down     <= (cmd_op == OP_DOWN);
`endif
                    end else if (w_accept) begin
                        r_done <= 1'b1;
                    end
                end
                ST_COUNT: begin
                    r_wrap     <= w_step_wrap;
                    r_step_cnt <= r_step_cnt - 1'b1;
                    if (r_step_cnt == STEP_W'(1)) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_cell u_cell (
            .clk (clk),
            .rst (rst),
            .J   (w_j[i]),
            .K   (w_k[i]),
            .Q   (Q[i]),
            .Qn  (Qn[i])
        );
    end

    assign done = r_done;
    assign wrap = r_wrap;

endmodule
